// File: rtl/beam_power_trigger.sv
// -----------------------------------------------------------------------------
// beam_power_trigger
//
// L1 beamformed power trigger on tclk. It forms NBEAMS delay-and-sum beams from
// 8 AGC'd channels (8 samples per clock) and computes the 8-sample power of
// each beam on every clock. Each beam power is compared against two
// independently loadable threshold sets:
//   set 0 : trigger threshold
//   set 1 : subthreshold
// The results go to the clock-crossing stretcher and the scalers.
//
// Ports
//   clk_i            tclk, the only clock
//   rst_n_i          synchronous active-low reset
//   dat_i            dat_i[c][5*s +: 5] = channel c, sample s (s = 0 oldest),
//                    signed 5-bit samples
//   thresh_i         [17:0] value for set 0, [35:18] value for set 1
//   thresh_wr_i      [k] shifts thresh_i[18k +: 18] into shadow chain k
//   thresh_update_i  [k] copies shadow chain k into active set k
//   trigger_o        [k][b] = power of beam b is strictly above active[k][b]
//
// Interface timing
//   There is no handshake. dat_i is consumed on every clock. thresh_wr_i and
//   thresh_update_i are single-cycle strobes: each cycle they are high counts
//   as exactly one action. trigger_o follows the dat_i word captured at edge n
//   at edge n+4, with no stalls and full throughput.
// -----------------------------------------------------------------------------
module beam_power_trigger #(
  parameter int NBEAMS = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [7:0][39:0]             dat_i,
  input  logic [35:0]                  thresh_i,
  input  logic [1:0]                   thresh_wr_i,
  input  logic [1:0]                   thresh_update_i,
  output logic [1:0][NBEAMS-1:0]       trigger_o
);

  localparam int NCHAN    = 8;
  localparam int NSAMP    = 8;
  localparam int AGC_BITS = 5;
  localparam int WORD_W   = NSAMP * AGC_BITS;
  localparam int SUM_W    = 8;   // -128..120, the sum of 8 signed 5-bit samples
  localparam int SQ_W     = 15;  // largest square is 128*128 = 16384
  localparam int PWR_W    = 18;  // largest power is 8*16384 = 131072
  localparam int THR_W    = 18;

  localparam logic [THR_W-1:0] THR_RESET = '1;  // above the largest power

  // ---------------------------------------------------------------------------
  // Stage 0: capture the input word and keep the previous word for the delays
  // ---------------------------------------------------------------------------
  logic [NCHAN-1:0][WORD_W-1:0] cur_q;
  logic [NCHAN-1:0][WORD_W-1:0] prev_q;

  // ---------------------------------------------------------------------------
  // Stage 1: beam sums
  // ---------------------------------------------------------------------------
  logic [NBEAMS-1:0][NSAMP-1:0][SUM_W-1:0] beam_d;
  logic [NBEAMS-1:0][NSAMP-1:0][SUM_W-1:0] beam_q;

  // Beam b delays channel c by (b*c) mod 8 samples. A tap that reaches back
  // past sample 0 of the current word comes from the previous word.
  always_comb begin
    logic [SUM_W-1:0]    acc;
    logic [AGC_BITS-1:0] smp;
    int                  d;
    int                  j;
    beam_d = '0;
    acc    = '0;
    smp    = '0;
    d      = 0;
    j      = 0;
    for (int b = 0; b < NBEAMS; b++) begin
      for (int s = 0; s < NSAMP; s++) begin
        acc = '0;
        for (int c = 0; c < NCHAN; c++) begin
          d = (b * c) % NSAMP;
          j = s - d;
          if (j >= 0) begin
            smp = cur_q[c][j*AGC_BITS +: AGC_BITS];
          end else begin
            smp = prev_q[c][(j+NSAMP)*AGC_BITS +: AGC_BITS];
          end
          acc = acc + {{(SUM_W-AGC_BITS){smp[AGC_BITS-1]}}, smp};
        end
        beam_d[b][s] = acc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: squares
  // ---------------------------------------------------------------------------
  logic [NBEAMS-1:0][NSAMP-1:0][SQ_W-1:0] sq_d;
  logic [NBEAMS-1:0][NSAMP-1:0][SQ_W-1:0] sq_q;

  // Square the magnitude. -128 maps to magnitude 128, which still fits in
  // 8 unsigned bits, and 128*128 fits exactly in the 15-bit product.
  always_comb begin
    logic [SUM_W-1:0] x;
    logic [SUM_W-1:0] mag;
    logic [SQ_W-1:0]  m;
    sq_d = '0;
    x    = '0;
    mag  = '0;
    m    = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      for (int s = 0; s < NSAMP; s++) begin
        x   = beam_q[b][s];
        mag = x[SUM_W-1] ? (~x + 1'b1) : x;
        m   = {{(SQ_W-SUM_W){1'b0}}, mag};
        sq_d[b][s] = m * m;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: power
  // ---------------------------------------------------------------------------
  logic [NBEAMS-1:0][PWR_W-1:0] pwr_d;
  logic [NBEAMS-1:0][PWR_W-1:0] pwr_q;

  always_comb begin
    logic [PWR_W-1:0] acc;
    pwr_d = '0;
    acc   = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      acc = '0;
      for (int s = 0; s < NSAMP; s++) begin
        acc = acc + {{(PWR_W-SQ_W){1'b0}}, sq_q[b][s]};
      end
      pwr_d[b] = acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Thresholds: two shadow chains and two active sets
  // ---------------------------------------------------------------------------
  logic [1:0][NBEAMS-1:0][THR_W-1:0] shadow_q;
  logic [1:0][NBEAMS-1:0][THR_W-1:0] active_q;

  // A write enters at the top entry and shifts the chain toward entry 0, so
  // after NBEAMS writes the first value written belongs to beam 0. An update
  // in the same cycle as a write copies the chain as it was before the shift,
  // because both read the pre-edge shadow values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shadow_q <= {(2*NBEAMS){THR_RESET}};
      active_q <= {(2*NBEAMS){THR_RESET}};
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (thresh_update_i[k]) begin
          active_q[k] <= shadow_q[k];
        end
        if (thresh_wr_i[k]) begin
          for (int i = 0; i < NBEAMS-1; i++) begin
            shadow_q[k][i] <= shadow_q[k][i+1];
          end
          shadow_q[k][NBEAMS-1] <= thresh_i[k*THR_W +: THR_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: compare. Equal power does not fire.
  // ---------------------------------------------------------------------------
  logic [1:0][NBEAMS-1:0] trig_d;

  always_comb begin
    trig_d = '0;
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < NBEAMS; b++) begin
        trig_d[k][b] = (pwr_q[b] > active_q[k][b]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cur_q     <= '0;
      prev_q    <= '0;
      beam_q    <= '0;
      sq_q      <= '0;
      pwr_q     <= '0;
      trigger_o <= '0;
    end else begin
      cur_q     <= dat_i;
      prev_q    <= cur_q;
      beam_q    <= beam_d;
      sq_q      <= sq_d;
      pwr_q     <= pwr_d;
      trigger_o <= trig_d;
    end
  end

endmodule

// File: tb/tb_beam_power_trigger.sv
module tb_beam_power_trigger;

  localparam int NB = 2;

  typedef logic [7:0][39:0]         word_t;
  typedef logic [NB-1:0][17:0]      pwr_t;
  typedef logic [1:0][NB-1:0]       trig_t;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst_n;
  word_t                dat;
  logic [35:0]          thr;
  logic [1:0]           wr;
  logic [1:0]           upd;
  trig_t                trigger;

  always #5 clk = ~clk;

  beam_power_trigger #(.NBEAMS(NB)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .dat_i           (dat),
    .thresh_i        (thr),
    .thresh_wr_i     (wr),
    .thresh_update_i (upd),
    .trigger_o       (trigger)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input trig_t got, input trig_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic word_t fill(input logic [4:0] v);
    word_t w;
    for (int c = 0; c < 8; c++)
      for (int s = 0; s < 8; s++)
        w[c][5*s +: 5] = v;
    return w;
  endfunction

  function automatic int beam_power(input word_t cw, input word_t pw, input int b);
    int p;
    int acc;
    int j;
    logic signed [4:0] v;
    p = 0;
    for (int s = 0; s < 8; s++) begin
      acc = 0;
      for (int c = 0; c < 8; c++) begin
        j = s - ((b * c) % 8);
        if (j >= 0) v = cw[c][5*j +: 5];
        else        v = pw[c][5*(j+8) +: 5];
        acc = acc + int'(v);
      end
      p = p + acc * acc;
    end
    return p;
  endfunction

  logic [NB*2-1:0]           exp_q[$];
  pwr_t                      pwr_pipe[$];
  word_t                     m_prev;
  logic [1:0][NB-1:0][17:0]  m_sh;
  logic [1:0][NB-1:0][17:0]  m_act;
  bit                        started = 1'b0;

  // Scoreboard producer: at each edge, model what the DUT will drive after it.
  always @(posedge clk) begin
    pwr_t  cp;
    pwr_t  f;
    trig_t e;
    e = '0;
    if (!rst_n) begin
      pwr_pipe.delete();
      for (int i = 0; i < 4; i++) pwr_pipe.push_back('0);
      m_prev  = '0;
      m_sh    = '1;
      m_act   = '1;
      started = 1'b1;
    end else if (started) begin
      for (int b = 0; b < NB; b++) cp[b] = 18'(beam_power(dat, m_prev, b));
      m_prev = dat;
      pwr_pipe.push_back(cp);
      f = pwr_pipe.pop_front();
      for (int k = 0; k < 2; k++)
        for (int b = 0; b < NB; b++)
          e[k][b] = (f[b] > m_act[k][b]);
      for (int k = 0; k < 2; k++) begin
        if (upd[k]) m_act[k] = m_sh[k];
        if (wr[k]) begin
          for (int i = 0; i < NB-1; i++) m_sh[k][i] = m_sh[k][i+1];
          m_sh[k][NB-1] = thr[18*k +: 18];
        end
      end
    end
    if (started) exp_q.push_back(e);
  end

  // Scoreboard monitor: compare on the opposite edge.
  always @(negedge clk) begin
    logic [NB*2-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", trigger, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_thr(input int k, input logic [17:0] v);
    thr[18*k +: 18] = v;
    wr[k] = 1'b1;
    cyc();
    wr[k] = 1'b0;
  endtask

  task automatic update(input logic [1:0] m);
    upd = m;
    cyc();
    upd = '0;
  endtask

  word_t w;

  initial begin
    rst_n = 1'b0;
    dat   = '0;
    thr   = '0;
    wr    = '0;
    upd   = '0;
    cyc(3);
    rst_n = 1'b1;
    check("reset_state", trigger, '0);

    // 1: reset thresholds block everything, even at +15
    dat = fill(5'd15);
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("t1_no_fire", trigger, '0);
    end

    // 2: threshold 511, constant +1 gives 512 on both beams
    dat = '0;
    cyc(6);
    write_thr(0, 18'd511);
    write_thr(0, 18'd511);
    update(2'b01);
    dat = fill(5'd1);
    cyc(4);
    check("t2_lat3", trigger, '0);
    cyc();
    check("t2_lat4", trigger, 4'b0001);  // beam1 still mixes in the zero word
    cyc();
    check("t2_lat5", trigger, 4'b0011);
    write_thr(0, 18'd512);
    write_thr(0, 18'd512);
    update(2'b01);
    cyc();
    check("t2_strict", trigger, '0);

    // 3: impulse steered into beam 1 (14400) but not beam 0 (1800)
    dat = '0;
    write_thr(0, 18'd10000);
    write_thr(0, 18'd10000);
    update(2'b01);
    cyc(6);
    w = '0;
    for (int c = 0; c < 8; c++) w[c][5*(7-c) +: 5] = 5'd15;
    dat = w;
    cyc();
    dat = '0;
    cyc(3);
    check("t3_lat3", trigger, '0);
    cyc();
    check("t3_lat4", trigger, 4'b0010);
    cyc();
    check("t3_lat5", trigger, '0);

    // 4: subthreshold only
    dat = fill(5'd1);
    write_thr(0, 18'h3FFFF);
    write_thr(0, 18'h3FFFF);
    write_thr(1, 18'd500);
    write_thr(1, 18'd500);
    update(2'b11);
    cyc(6);
    check("t4_sub_only", trigger, 4'b1100);

    // 5: pre-shift copy on simultaneous write and update; power 72 per beam
    w = '0;
    for (int s = 0; s < 8; s++) w[0][5*s +: 5] = 5'd3;
    dat = w;
    cyc(6);
    check("t5_base", trigger, '0);
    write_thr(0, 18'd100);
    write_thr(0, 18'd100);
    cyc(2);
    check("t5_no_update", trigger, '0);
    thr[17:0] = 18'd7;
    wr  = 2'b01;
    upd = 2'b01;
    cyc();
    wr  = '0;
    upd = '0;
    cyc();
    check("t5_preshift", trigger, '0);
    update(2'b01);
    cyc();
    check("t5_after_update", trigger, 4'b0010);

    // 6: maximum power 131072 against 131071 and 131072, then reset
    dat = fill(5'b10000);
    write_thr(0, 18'd131071);
    write_thr(0, 18'd131071);
    write_thr(1, 18'd131072);
    write_thr(1, 18'd131072);
    update(2'b11);
    cyc(6);
    check("t6_max", trigger, 4'b0011);
    rst_n = 1'b0;
    cyc();
    check("t6_reset_out", trigger, '0);
    rst_n = 1'b1;
    cyc(8);
    check("t6_reset_thr", trigger, '0);

    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
